d_cache_burst: RTL and testbench

Direct-mapped, write-through data cache with multi-word lines and burst refill; the next-generation L1 data cache between the MEM stage and the memory/bus interface. It extends the single-word cache design with parametrised line size, a refill state machine, byte-lane write merge on write hits, and no-allocate write misses. Addresses in the uncached window 0xBFAF_xxxx bypass the arrays and are translated to physical 0x1FAF_xxxx.

---
 rtl/d_cache_pkg.sv | 26 ++
 rtl/d_cache_array.sv | 65 ++++++
 rtl/d_cache_burst.sv | 247 ++++++++++++++++++++++++
 tb/tb_d_cache_burst.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/d_cache_pkg.sv
// Shared types and constants for the burst-refill L1 data cache.
// The uncached window 0xBFAF_xxxx maps onto physical 0x1FAF_xxxx.
package d_cache_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REFILL = 3'd1,
    S_RESP   = 3'd2,
    S_WRITE  = 3'd3,
    S_UNC    = 3'd4
  } state_t;

  localparam logic [15:0] UNC_PREFIX = 16'hbfaf;
  localparam logic [15:0] UNC_MAP    = 16'h1faf;

  // Expands a 4-bit byte-lane enable into a 32-bit bit mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = {8{be[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/d_cache_array.sv
// Valid/tag/data storage for the direct-mapped cache: asynchronous read,
// per-word byte-lane write, and separate tag-install / invalidate controls.
module d_cache_array
  import d_cache_pkg::*;
#(
  parameter int TW       = 22,
  parameter int C_INDEX  = 6,
  parameter int C_OFFSET = 2
) (
  input  logic                clk,
  input  logic                clrn,
  input  logic [C_INDEX-1:0]  r_index,
  input  logic [C_OFFSET-1:0] r_offset,
  output logic                r_valid,
  output logic [TW-1:0]       r_tag,
  output logic [31:0]         r_word,
  input  logic [C_INDEX-1:0]  w_index,
  input  logic [C_OFFSET-1:0] w_offset,
  input  logic                w_en,
  input  logic [3:0]          w_be,
  input  logic [31:0]         w_data,
  input  logic                tag_en,
  input  logic [TW-1:0]       w_tag,
  input  logic                inv_en
);

  localparam int LINES = 1 << C_INDEX;
  localparam int WORDS = 1 << (C_INDEX + C_OFFSET);

  logic [LINES-1:0] valid_q;
  logic [TW-1:0]    tag_q  [LINES];
  logic [31:0]      data_q [WORDS];
  logic [31:0]      wmask;

  assign wmask = lane_mask(w_be);

  // Only the valid bits are reset; tags and data are don't-care until valid.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      valid_q <= '0;
    end else if (tag_en) begin
      valid_q[w_index] <= 1'b1;
    end else if (inv_en) begin
      valid_q[w_index] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_en) begin
      tag_q[w_index] <= w_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (w_en) begin
      data_q[{w_index, w_offset}] <= (data_q[{w_index, w_offset}] & ~wmask) |
                                     (w_data & wmask);
    end
  end

  assign r_valid = valid_q[r_index];
  assign r_tag   = tag_q[r_index];
  assign r_word  = data_q[{r_index, r_offset}];

endmodule

// File: rtl/d_cache_burst.sv
// Direct-mapped write-through L1 data cache with burst line refill and
// no-allocate writes. Define D_CACHE_STATS_EN to add hit_cnt / miss_cnt.
module d_cache_burst
  import d_cache_pkg::*;
#(
  parameter int A_WIDTH  = 32,
  parameter int C_INDEX  = 6,
  parameter int C_OFFSET = 2
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [A_WIDTH-1:0] p_a,
  input  logic [31:0]        p_dout,
  input  logic               p_strobe,
  input  logic               p_rw,
  input  logic [3:0]         p_wen,
  input  logic [3:0]         p_ren,
  input  logic               flush_except,
  output logic               p_ready,
  output logic [31:0]        p_din,
  input  logic [31:0]        m_dout,
  input  logic               m_ready,
  output logic [31:0]        m_din,
  output logic [A_WIDTH-1:0] m_a,
  output logic               m_strobe,
  output logic               m_rw,
  output logic [2:0]         dbg_state
`ifdef D_CACHE_STATS_EN
  ,
  output logic [31:0]        hit_cnt,
  output logic [31:0]        miss_cnt
`endif
);

  // Handshake on both ports: the requester holds strobe (and its address and
  // data) until ready; a transfer completes in the cycle strobe & ready are both 1.

  localparam int TW = A_WIDTH - C_INDEX - C_OFFSET - 2;

  state_t                state_q;
  logic [A_WIDTH-1:0]    req_a_q;
  logic                  req_rw_q;
  logic                  kill_q;
  logic [C_OFFSET-1:0]   beat_q;

  logic [TW-1:0]         lk_tag;
  logic [C_INDEX-1:0]    lk_index;
  logic [C_OFFSET-1:0]   lk_off;
  logic                  r_valid;
  logic [TW-1:0]         r_tag;
  logic [31:0]           r_word;
  logic                  hit;
  logic                  p_uncached;
  logic                  idle_go;
  logic                  rd_hit;
  logic                  refill_start;
  logic                  kill_now;
  logic                  last_beat;

  logic                  arr_wen;
  logic [3:0]            arr_be;
  logic [31:0]           arr_wdata;
  logic [C_OFFSET-1:0]   arr_woff;
  logic                  arr_tag_en;
  logic                  arr_inv_en;

  logic                  unused_ren;
  assign unused_ren = ^p_ren;

  // In IDLE the live CPU address is looked up; afterwards the latched one.
  always_comb begin
    if (state_q == S_IDLE) begin
      lk_tag   = p_a[A_WIDTH-1 -: TW];
      lk_index = p_a[C_OFFSET+C_INDEX+1 : C_OFFSET+2];
      lk_off   = p_a[C_OFFSET+1 : 2];
    end else begin
      lk_tag   = req_a_q[A_WIDTH-1 -: TW];
      lk_index = req_a_q[C_OFFSET+C_INDEX+1 : C_OFFSET+2];
      lk_off   = req_a_q[C_OFFSET+1 : 2];
    end
  end

  d_cache_array #(
    .TW       (TW),
    .C_INDEX  (C_INDEX),
    .C_OFFSET (C_OFFSET)
  ) u_array (
    .clk      (clk),
    .clrn     (clrn),
    .r_index  (lk_index),
    .r_offset (lk_off),
    .r_valid  (r_valid),
    .r_tag    (r_tag),
    .r_word   (r_word),
    .w_index  (lk_index),
    .w_offset (arr_woff),
    .w_en     (arr_wen),
    .w_be     (arr_be),
    .w_data   (arr_wdata),
    .tag_en   (arr_tag_en),
    .w_tag    (lk_tag),
    .inv_en   (arr_inv_en)
  );

  assign hit          = r_valid && (r_tag == lk_tag);
  assign p_uncached   = (p_a[31:16] == UNC_PREFIX);
  assign idle_go      = (state_q == S_IDLE) && p_strobe && !flush_except;
  assign rd_hit       = idle_go && !p_rw && !p_uncached && hit;
  assign refill_start = idle_go && !p_rw && !p_uncached && !hit;
  assign kill_now     = kill_q || flush_except;
  assign last_beat    = (beat_q == {C_OFFSET{1'b1}});

  always_comb begin
    p_ready    = 1'b0;
    p_din      = r_word;
    arr_wen    = 1'b0;
    arr_be     = 4'h0;
    arr_wdata  = m_dout;
    arr_woff   = beat_q;
    arr_tag_en = 1'b0;
    arr_inv_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        p_ready    = rd_hit;
        arr_inv_en = refill_start;
      end
      S_REFILL: begin
        if (m_ready && !kill_now) begin
          arr_wen    = 1'b1;
          arr_be     = 4'hf;
          arr_tag_en = last_beat;
        end
      end
      S_RESP: begin
        p_ready = 1'b1;
      end
      S_WRITE: begin
        // Write-through; only a hit merges the stored lanes into the line.
        if (m_ready && !kill_now) begin
          p_ready   = 1'b1;
          arr_wen   = hit;
          arr_be    = p_wen;
          arr_wdata = p_dout;
          arr_woff  = lk_off;
        end
      end
      S_UNC: begin
        if (m_ready && !kill_now) begin
          p_ready = 1'b1;
          p_din   = m_dout;
        end
      end
      default: begin
        p_ready = 1'b0;
      end
    endcase
  end

  // Memory-side outputs decode purely from registered state.
  always_comb begin
    case (state_q)
      S_REFILL: m_a = {req_a_q[A_WIDTH-1:C_OFFSET+2], beat_q, 2'b00};
      S_UNC:    m_a = A_WIDTH'({UNC_MAP, req_a_q[15:0]});
      default:  m_a = req_a_q;
    endcase
  end

  assign m_strobe  = (state_q == S_REFILL) || (state_q == S_WRITE) || (state_q == S_UNC);
  assign m_rw      = (state_q == S_WRITE) || ((state_q == S_UNC) && req_rw_q);
  assign m_din     = p_dout;
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q  <= S_IDLE;
      req_a_q  <= '0;
      req_rw_q <= 1'b0;
      beat_q   <= '0;
      kill_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (idle_go) begin
            req_a_q  <= p_a;
            req_rw_q <= p_rw;
            beat_q   <= '0;
            kill_q   <= 1'b0;
            if (p_uncached) begin
              state_q <= S_UNC;
            end else if (p_rw) begin
              state_q <= S_WRITE;
            end else if (!hit) begin
              state_q <= S_REFILL;
            end
          end
        end
        S_REFILL: begin
          // A flushed refill still finishes its outstanding beat, then drops.
          if (m_ready) begin
            if (kill_now) begin
              state_q <= S_IDLE;
              kill_q  <= 1'b0;
            end else begin
              beat_q <= beat_q + 1'b1;
              if (last_beat) begin
                state_q <= S_RESP;
              end
            end
          end else if (flush_except) begin
            kill_q <= 1'b1;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        S_WRITE, S_UNC: begin
          if (m_ready) begin
            state_q <= S_IDLE;
            kill_q  <= 1'b0;
          end else if (flush_except) begin
            kill_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef D_CACHE_STATS_EN
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (rd_hit && (hit_cnt != 32'hffff_ffff)) begin
        hit_cnt <= hit_cnt + 32'd1;
      end
      if (refill_start && (miss_cnt != 32'hffff_ffff)) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_d_cache_burst.sv
// Bench for d_cache_burst: CPU driver, randomized-latency memory responder,
// and a line-level reference model of tags plus a flat backing memory.
module tb_d_cache_burst;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic [31:0] p_a = '0;
  logic [31:0] p_dout = '0;
  logic        p_strobe = 1'b0;
  logic        p_rw = 1'b0;
  logic [3:0]  p_wen = '0;
  logic [3:0]  p_ren = '0;
  logic        flush_except = 1'b0;
  logic        p_ready;
  logic [31:0] p_din;
  logic [31:0] m_dout = '0;
  logic        m_ready = 1'b0;
  logic [31:0] m_din;
  logic [31:0] m_a;
  logic        m_strobe;
  logic        m_rw;
  logic [2:0]  dbg_state;
`ifdef D_CACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  d_cache_burst dut (
    .clk          (clk),
    .clrn         (clrn),
    .p_a          (p_a),
    .p_dout       (p_dout),
    .p_strobe     (p_strobe),
    .p_rw         (p_rw),
    .p_wen        (p_wen),
    .p_ren        (p_ren),
    .flush_except (flush_except),
    .p_ready      (p_ready),
    .p_din        (p_din),
    .m_dout       (m_dout),
    .m_ready      (m_ready),
    .m_din        (m_din),
    .m_a          (m_a),
    .m_strobe     (m_strobe),
    .m_rw         (m_rw),
    .dbg_state    (dbg_state)
`ifdef D_CACHE_STATS_EN
    ,
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [logic [31:0]];
  bit          ref_v [64];
  logic [31:0] ref_t [64];
  int          model_hits = 0;
  int          model_misses = 0;

  // Scoreboard of expected memory beats (word address, direction).
  logic [31:0] exp_q[$];
  logic        exp_rw_q[$];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] w;
    w = a & ~32'h3;
    if (ref_mem.exists(w)) return ref_mem[w];
    return w ^ 32'h9e37_79b9;
  endfunction

  task automatic mem_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] w, old;
    w = a & ~32'h3;
    old = mem_rd(w);
    for (int b = 0; b < 4; b++) begin
      if (be[b]) old[8*b +: 8] = d[8*b +: 8];
    end
    ref_mem[w] = old;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) ref_v[i] = 1'b0;
    exp_q.delete();
    exp_rw_q.delete();
    model_hits = 0;
    model_misses = 0;
  endtask

  // Predicts memory traffic, load data and hit/miss for one CPU access.
  task automatic model_access(input logic [31:0] a, input logic rw, input logic [3:0] wen,
                              input logic [31:0] d, output logic [31:0] ed, output bit eh);
    int idx;
    logic [31:0] tag, base;
    ed = '0;
    eh = 1'b0;
    if (a[31:16] == 16'hbfaf) begin
      base = {16'h1faf, a[15:0]};
      exp_q.push_back(base);
      exp_rw_q.push_back(rw);
      if (rw) mem_wr(base, d, wen);
      else ed = mem_rd(base);
    end else begin
      idx = int'((a >> 4) % 64);
      tag = a >> 10;
      eh = ref_v[idx] && (ref_t[idx] == tag);
      if (rw) begin
        exp_q.push_back(a);
        exp_rw_q.push_back(1'b1);
        mem_wr(a, d, wen);
      end else begin
        if (eh) begin
          model_hits++;
        end else begin
          model_misses++;
          base = a & ~32'hf;
          for (int b = 0; b < 4; b++) begin
            exp_q.push_back(base + 32'(4 * b));
            exp_rw_q.push_back(1'b0);
          end
          ref_v[idx] = 1'b1;
          ref_t[idx] = tag;
        end
        ed = mem_rd(a);
      end
    end
  endtask

  // ---------------- memory responder ----------------
  int fixed_delay = -1;
  int wait_cnt = 0;
  int beat_cnt = 0;

  initial begin
    logic [31:0] ea;
    logic        erw;
    forever begin
      @(posedge clk);
      #1;
      if (m_strobe && wait_cnt == 0) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL mem_beat unexpected: m_a=%h m_rw=%0d, no beat required", m_a, m_rw);
        end else begin
          ea = exp_q.pop_front();
          erw = exp_rw_q.pop_front();
          if (m_a !== ea || m_rw !== erw) begin
            n_errors++;
            $display("FAIL mem_beat: got a=%h rw=%0d, required a=%h rw=%0d", m_a, m_rw, ea, erw);
          end
        end
        m_ready = 1'b1;
        m_dout = m_rw ? 32'h0 : mem_rd(m_a);
        beat_cnt++;
        wait_cnt = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 2));
      end else begin
        m_ready = 1'b0;
        if (m_strobe && wait_cnt > 0) wait_cnt--;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic cpu_access(input logic [31:0] a, input logic rw, input logic [3:0] wen,
                            input logic [31:0] d, output logic [31:0] rd,
                            output int cyc, output bit to);
    p_a = a;
    p_rw = rw;
    p_wen = rw ? wen : 4'h0;
    p_ren = rw ? 4'h0 : 4'hf;
    p_dout = d;
    p_strobe = 1'b1;
    rd = '0;
    cyc = -1;
    to = 1'b1;
    for (int i = 0; i < 200 && to; i++) begin
      @(negedge clk);
      if (p_ready) begin
        rd = p_din;
        cyc = i;
        to = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    p_strobe = 1'b0;
    p_rw = 1'b0;
  endtask

  // One access with model prediction; results handed back for inline checking.
  task automatic run_op(input logic [31:0] a, input logic rw, input logic [3:0] wen,
                        input logic [31:0] d, output logic [31:0] ed, output bit eh,
                        output logic [31:0] rd, output int cyc, output bit to, output int min_cyc);
    model_access(a, rw, wen, d, ed, eh);
    if (eh && !rw) min_cyc = 0;
    else if (!rw && a[31:16] != 16'hbfaf) min_cyc = 5;
    else min_cyc = 1;
    cpu_access(a, rw, wen, d, rd, cyc, to);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clrn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    n_checks++;
    if (p_ready !== 1'b0) begin n_errors++; $display("FAIL reset_p_ready: got %b required 0", p_ready); end
    n_checks++;
    if (m_strobe !== 1'b0) begin n_errors++; $display("FAIL reset_m_strobe: got %b required 0", m_strobe); end
    n_checks++;
    if (m_rw !== 1'b0) begin n_errors++; $display("FAIL reset_m_rw: got %b required 0", m_rw); end
    n_checks++;
    if (dbg_state !== 3'd0) begin n_errors++; $display("FAIL reset_state: got %0d required 0", dbg_state); end
`ifdef D_CACHE_STATS_EN
    n_checks++;
    if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
      n_errors++; $display("FAIL reset_stats: got %0d/%0d required 0/0", hit_cnt, miss_cnt);
    end
`endif
    clrn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Generic per-op checks are written out in each scenario below.
  task automatic test_refill_read();
    logic [31:0] ed, rd; bit eh, to; int cyc, mc;
    for (int i = 0; i < 4; i++) ref_mem[32'h100 + 32'(4 * i)] = 32'hA0 + 32'(i);
    for (int r = 0; r < 2; r++) begin
      run_op(32'h0000_0104, 1'b0, 4'h0, 32'h0, ed, eh, rd, cyc, to, mc);
      n_checks++;
      if (to || rd !== 32'hA1) begin n_errors++; $display("FAIL refill_read%0d: got %h to=%0d required 000000a1", r, rd, to); end
      n_checks++;
      if (r == 1 ? cyc != 0 : cyc < 5) begin n_errors++; $display("FAIL refill_latency%0d: got %0d cycles", r, cyc); end
      n_checks++;
      if (exp_q.size() != 0) begin n_errors++; $display("FAIL refill_beats%0d: %0d beats missing, required 0", r, exp_q.size()); end
    end
  endtask

  task automatic test_write_hit();
    logic [31:0] ed, rd; bit eh, to; int cyc, mc;
    run_op(32'h0000_0106, 1'b1, 4'b0100, 32'h0055_0000, ed, eh, rd, cyc, to, mc);
    n_checks++;
    if (to || cyc < 1 || exp_q.size() != 0) begin
      n_errors++; $display("FAIL write_hit: to=%0d cyc=%0d left=%0d required mem write done", to, cyc, exp_q.size());
    end
    run_op(32'h0000_0104, 1'b0, 4'h0, 32'h0, ed, eh, rd, cyc, to, mc);
    n_checks++;
    if (to || rd !== 32'h0055_00A1) begin n_errors++; $display("FAIL write_merge: got %h required 005500a1", rd); end
    n_checks++;
    if (cyc != 0) begin n_errors++; $display("FAIL write_merge_hit: got %0d cycles required 0", cyc); end
  endtask

  task automatic test_write_miss();
    logic [31:0] ed, rd, wd; bit eh, to; int cyc, mc;
    wd = $urandom;
    run_op(32'h0000_2000, 1'b1, 4'hf, wd, ed, eh, rd, cyc, to, mc);
    n_checks++;
    if (to || exp_q.size() != 0) begin n_errors++; $display("FAIL write_miss: to=%0d left=%0d required 0/0", to, exp_q.size()); end
    run_op(32'h0000_2000, 1'b0, 4'h0, 32'h0, ed, eh, rd, cyc, to, mc);
    n_checks++;
    if (to || rd !== wd) begin n_errors++; $display("FAIL write_miss_read: got %h required %h", rd, wd); end
    n_checks++;
    if (cyc < 5 || exp_q.size() != 0) begin n_errors++; $display("FAIL write_miss_noalloc: got cyc=%0d left=%0d required refill", cyc, exp_q.size()); end
  endtask

  task automatic test_uncached();
    logic [31:0] ed, rd; bit eh, to; int cyc, mc;
    ref_mem[32'h1FAF_F000] = 32'hC0DE_0001;
    for (int r = 0; r < 2; r++) begin
      run_op(32'hBFAF_F000, 1'b0, 4'h0, 32'h0, ed, eh, rd, cyc, to, mc);
      n_checks++;
      if (to || rd !== 32'hC0DE_0001) begin n_errors++; $display("FAIL uncached_read%0d: got %h required c0de0001", r, rd); end
      n_checks++;
      if (cyc < 1 || exp_q.size() != 0) begin n_errors++; $display("FAIL uncached_beat%0d: cyc=%0d left=%0d required one beat", r, cyc, exp_q.size()); end
    end
  endtask

  task automatic test_flush_refill();
    logic [31:0] ed, rd; bit eh, to, seen; int cyc, mc, b0;
    model_access(32'h0000_0300, 1'b0, 4'h0, 32'h0, ed, eh);
    fixed_delay = 3;
    wait_cnt = 3;
    b0 = beat_cnt;
    p_a = 32'h0000_0300; p_rw = 1'b0; p_ren = 4'hf; p_strobe = 1'b1;
    seen = 1'b0; to = 1'b1;
    for (int i = 0; i < 100 && to; i++) begin
      @(negedge clk);
      if (p_ready) seen = 1'b1;
      if (beat_cnt - b0 >= 2) to = 1'b0;
    end
    @(posedge clk); #1;
    flush_except = 1'b1; p_strobe = 1'b0;
    @(posedge clk); #1;
    flush_except = 1'b0;
    if (!to) begin
      to = 1'b1;
      for (int i = 0; i < 100 && to; i++) begin
        @(negedge clk);
        if (p_ready) seen = 1'b1;
        if (!m_strobe) to = 1'b0;
      end
    end
    n_checks++;
    if (to) begin n_errors++; $display("FAIL flush_timeout: m_strobe still %b", m_strobe); end
    n_checks++;
    if (seen) begin n_errors++; $display("FAIL flush_p_ready: got 1 required 0"); end
    n_checks++;
    if (beat_cnt - b0 != 3) begin n_errors++; $display("FAIL flush_beats: got %0d required 3", beat_cnt - b0); end
    n_checks++;
    if (exp_q.size() != 1) begin n_errors++; $display("FAIL flush_left: got %0d required 1", exp_q.size()); end
    exp_q.delete();
    exp_rw_q.delete();
    ref_v[6'h30] = 1'b0;
    fixed_delay = -1;
    run_op(32'h0000_0300, 1'b0, 4'h0, 32'h0, ed, eh, rd, cyc, to, mc);
    n_checks++;
    if (to || rd !== ed || cyc < 5 || exp_q.size() != 0) begin
      n_errors++; $display("FAIL flush_reread: got %h cyc=%0d required %h after refill", rd, cyc, ed);
    end
  endtask

  task automatic test_alias();
    logic [31:0] ed, rd; bit eh, to; int cyc, mc;
    logic [31:0] seq [3];
    seq[0] = 32'h0000_0100; seq[1] = 32'h0000_1100; seq[2] = 32'h0000_0100;
    for (int k = 0; k < 3; k++) begin
      run_op(seq[k], 1'b0, 4'h0, 32'h0, ed, eh, rd, cyc, to, mc);
      n_checks++;
      if (to || rd !== ed) begin n_errors++; $display("FAIL alias_data%0d: got %h required %h", k, rd, ed); end
      n_checks++;
      if ((k > 0 && cyc < 5) || exp_q.size() != 0) begin
        n_errors++; $display("FAIL alias_evict%0d: got cyc=%0d left=%0d required miss", k, cyc, exp_q.size());
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] ed, rd; bit eh, to; int cyc, mc, b0;
    model_access(32'h0000_0500, 1'b0, 4'h0, 32'h0, ed, eh);
    fixed_delay = 2;
    b0 = beat_cnt;
    p_a = 32'h0000_0500; p_rw = 1'b0; p_ren = 4'hf; p_strobe = 1'b1;
    for (int i = 0; i < 100 && (beat_cnt - b0) < 1; i++) @(negedge clk);
    clrn = 1'b0;
    #1;
    n_checks++;
    if (m_strobe !== 1'b0 || dbg_state !== 3'd0) begin
      n_errors++; $display("FAIL reset_abort: m_strobe=%b state=%0d required 0/0", m_strobe, dbg_state);
    end
    p_strobe = 1'b0;
    model_reset();
    @(posedge clk); #1;
    clrn = 1'b1;
    fixed_delay = -1;
    run_op(32'h0000_0104, 1'b0, 4'h0, 32'h0, ed, eh, rd, cyc, to, mc);
    n_checks++;
    if (to || rd !== 32'h0055_00A1 || cyc < 5 || exp_q.size() != 0) begin
      n_errors++; $display("FAIL reset_invalidate: got %h cyc=%0d required 005500a1 via refill", rd, cyc);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d, ed, rd; logic rw; logic [3:0] wen; bit eh, to; int cyc, mc;
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 7) == 0) a = {16'hbfaf, 8'h20, 4'($urandom_range(0, 15)), 4'h0};
      else a = (32'($urandom_range(0, 2)) << 10) | (32'($urandom_range(0, 7)) << 4) |
               (32'($urandom_range(0, 3)) << 2);
      rw = 1'($urandom_range(0, 1));
      wen = 4'($urandom_range(1, 15));
      d = $urandom;
      run_op(a, rw, wen, d, ed, eh, rd, cyc, to, mc);
      n_checks++;
      if (to) begin n_errors++; $display("FAIL rand%0d_timeout: a=%h no p_ready", n, a); end
      n_checks++;
      if (!rw && rd !== ed) begin n_errors++; $display("FAIL rand%0d_data: a=%h got %h required %h", n, a, rd, ed); end
      n_checks++;
      if ((mc == 0 && cyc != 0) || cyc < mc) begin
        n_errors++; $display("FAIL rand%0d_latency: a=%h rw=%0d got %0d required %s%0d", n, a, rw, cyc, mc == 0 ? "" : ">=", mc);
      end
      n_checks++;
      if (exp_q.size() != 0) begin n_errors++; $display("FAIL rand%0d_beats: a=%h %0d beats missing", n, a, exp_q.size()); end
      exp_q.delete();
      exp_rw_q.delete();
    end
  endtask

  task automatic test_stats();
`ifdef D_CACHE_STATS_EN
    n_checks++;
    if (hit_cnt !== 32'(model_hits) || miss_cnt !== 32'(model_misses)) begin
      n_errors++; $display("FAIL stats: got %0d/%0d required %0d/%0d", hit_cnt, miss_cnt, model_hits, model_misses);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_refill_read();
    test_write_hit();
    test_write_miss();
    test_uncached();
    test_flush_refill();
    test_alias();
    test_reset_mid_burst();
    test_random();
    test_stats();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
